// File: rtl/reg_file_param.sv
// Parametrised register file: NUM_RD registered read ports, per-lane writes and read masking.
// A synchronous reset starts a clear sweep. Define REGFILE_WR_BYPASS_EN to forward same-edge write data to reads.
module reg_file_param #(
    parameter int DATA_W = 16,
    parameter int LANE_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_req,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W/LANE_W-1:0]   rd_lane_mask,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic                       rd_valid,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DATA_W/LANE_W-1:0]   wr_lane_en,
    output logic                       busy
);

    localparam int LANES = DATA_W / LANE_W;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0]        clr_ptr;
    logic                     clr_last;
    logic                     clear_en;
    logic                     wr_en;
    logic                     rd_en;
    logic                     wr_in_range;
    logic [DATA_W-1:0]        wr_bits;
    logic [DATA_W-1:0]        rd_bits;
    logic [NUM_RD*DATA_W-1:0] rd_next;
    logic [DATA_W-1:0]        gpr [DEPTH];

    assign clr_last    = (clr_ptr == ADDR_W'(DEPTH - 1));
    assign wr_in_range = (32'(wr_addr) < DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_next;
            if (clear_en) begin
                clr_ptr <= clr_last ? '0 : clr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_last) state_next = IDLE;
            IDLE:    state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        clear_en = (state == CLEAR);
        busy     = (state == CLEAR);
        wr_en    = (state == IDLE) && (|wr_lane_en) && wr_in_range;
        rd_en    = (state == IDLE) && rd_req;
    end

    // Lane enables and read masks widened to one bit per data bit.
    always_comb begin
        wr_bits = '0;
        rd_bits = '0;
        for (int i = 0; i < LANES; i++) begin
            wr_bits[i*LANE_W +: LANE_W] = {LANE_W{wr_lane_en[i]}};
            rd_bits[i*LANE_W +: LANE_W] = {LANE_W{rd_lane_mask[i]}};
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] stored;
        logic [DATA_W-1:0] word;

        assign addr   = rd_addr[p*ADDR_W +: ADDR_W];
        assign stored = (32'(addr) < DEPTH) ? gpr[addr] : '0;
`ifdef REGFILE_WR_BYPASS_EN
        // wr_en already excludes CLEAR and out-of-range write addresses.
        assign word = (wr_en && (addr == wr_addr)) ? ((stored & ~wr_bits) | (wr_data & wr_bits))
                                                   : stored;
`else
        assign word = stored;
`endif
        assign rd_next[p*DATA_W +: DATA_W] = word & rd_bits;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_next;
            end
        end
    end

    // The array itself is left alone on the reset edge; the sweep does the clearing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clear_en) begin
                gpr[clr_ptr] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wr_lane_en[i]) begin
                        gpr[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: a DEPTH=8 and a DEPTH=6 instance share stimulus
// and are compared every cycle against a behavioural model; honours REGFILE_WR_BYPASS_EN.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0;
    logic [5:0]  rd_addr = '0;
    logic [1:0]  rd_lane_mask = '0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_lane_en = '0;

    logic [31:0] rd_data8, rd_data6;
    logic        rd_valid8, rd_valid6;
    logic        busy8, busy6;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] m_mem [2][8];
    int          m_depth [2] = '{8, 6};
    logic [31:0] m_data [2];
    logic        m_valid [2];
    logic        m_busy [2];
    int          m_ptr [2];

    always #5 clk = ~clk;

    reg_file_param #(.DATA_W(16), .LANE_W(8), .DEPTH(8), .ADDR_W(3), .NUM_RD(2)) dut8 (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_lane_mask(rd_lane_mask),
        .rd_data(rd_data8), .rd_valid(rd_valid8), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_lane_en(wr_lane_en), .busy(busy8)
    );

    reg_file_param #(.DATA_W(16), .LANE_W(8), .DEPTH(6), .ADDR_W(3), .NUM_RD(2)) dut6 (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_lane_mask(rd_lane_mask),
        .rd_data(rd_data6), .rd_valid(rd_valid6), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_lane_en(wr_lane_en), .busy(busy6)
    );

    task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour per instance: reset arms a sweep of DEPTH edges, then plain
    // masked read-before-write (or forwarded) semantics on a word array.
    task automatic modelEdge();
        logic [15:0] wmask, rmask, word;
        int a;
        wmask = {{8{wr_lane_en[1]}}, {8{wr_lane_en[0]}}};
        rmask = {{8{rd_lane_mask[1]}}, {8{rd_lane_mask[0]}}};
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_data[k]  = '0;
                m_valid[k] = 1'b0;
                m_busy[k]  = 1'b1;
                m_ptr[k]   = 0;
            end else if (m_busy[k]) begin
                m_mem[k][m_ptr[k]] = '0;
                m_ptr[k]++;
                if (m_ptr[k] == m_depth[k]) m_busy[k] = 1'b0;
                m_valid[k] = 1'b0;
            end else begin
                if (rd_req) begin
                    for (int p = 0; p < 2; p++) begin
                        a = int'(rd_addr[p*3 +: 3]);
                        word = (a < m_depth[k]) ? m_mem[k][a] : 16'h0000;
`ifdef REGFILE_WR_BYPASS_EN
                        if (a == int'(wr_addr) && int'(wr_addr) < m_depth[k])
                            word = (word & ~wmask) | (wr_data & wmask);
`endif
                        m_data[k][p*16 +: 16] = word & rmask;
                    end
                    m_valid[k] = 1'b1;
                end else begin
                    m_valid[k] = 1'b0;
                end
                if (int'(wr_addr) < m_depth[k])
                    m_mem[k][wr_addr] = (m_mem[k][wr_addr] & ~wmask) | (wr_data & wmask);
            end
        end
    endtask

    task automatic checkOutput();
        checkOne("busy8",  {31'b0, busy8},     {31'b0, m_busy[0]});
        checkOne("valid8", {31'b0, rd_valid8}, {31'b0, m_valid[0]});
        checkOne("data8",  rd_data8,           m_data[0]);
        checkOne("busy6",  {31'b0, busy6},     {31'b0, m_busy[1]});
        checkOne("valid6", {31'b0, rd_valid6}, {31'b0, m_valid[1]});
        checkOne("data6",  rd_data6,           m_data[1]);
    endtask

    task automatic applyStimulus(input logic r, input logic rq, input logic [2:0] a0,
                                 input logic [2:0] a1, input logic [1:0] m, input logic [2:0] wa,
                                 input logic [15:0] wd, input logic [1:0] we);
        rst          = r;
        rd_req       = rq;
        rd_addr      = {a1, a0};
        rd_lane_mask = m;
        wr_addr      = wa;
        wr_data      = wd;
        wr_lane_en   = we;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 16'h0000, 2'b00);
    endtask

    task automatic writeReg(input logic [2:0] wa, input logic [15:0] wd, input logic [1:0] we);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 2'b00, wa, wd, we);
    endtask

    task automatic readRegs(input logic [2:0] a0, input logic [2:0] a1, input logic [1:0] m);
        applyStimulus(1'b0, 1'b1, a0, a1, m, 3'd0, 16'h0000, 2'b00);
    endtask

    logic [31:0] exp_hazard;

    initial begin
        for (int k = 0; k < 2; k++) m_busy[k] = 1'b0;

        // Reset for two cycles, then the sweep.
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 16'h0000, 2'b00);
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 16'h0000, 2'b00);
        checkOne("reset_busy", {31'b0, busy8}, 32'd1);
        idle(7);
        checkOne("busy_edge7", {31'b0, busy8}, 32'd1);
        idle(1);
        checkOne("busy_edge8", {31'b0, busy8}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            readRegs(3'(i), 3'(7 - i), 2'b11);
            checkOne("swept_zero", rd_data8, 32'h0000_0000);
        end

        // Lane writes and read masking.
        writeReg(3'd3, 16'hA5C3, 2'b11);
        writeReg(3'd3, 16'h7700, 2'b10);
        readRegs(3'd3, 3'd3, 2'b11);
        checkOne("r3_lanes", rd_data8, 32'h77C3_77C3);
        readRegs(3'd3, 3'd3, 2'b01);
        checkOne("mask01", rd_data8, 32'h00C3_00C3);
        readRegs(3'd3, 3'd3, 2'b10);
        checkOne("mask10", rd_data8, 32'h7700_7700);
        readRegs(3'd3, 3'd3, 2'b00);
        checkOne("mask00", rd_data8, 32'h0000_0000);
        checkOne("mask00_valid", {31'b0, rd_valid8}, 32'd1);
        idle(1);
        checkOne("hold_data", rd_data8, 32'h0000_0000);

        // Same-edge read and write to r5.
        writeReg(3'd5, 16'h1111, 2'b11);
        applyStimulus(1'b0, 1'b1, 3'd5, 3'd5, 2'b11, 3'd5, 16'h2222, 2'b11);
`ifdef REGFILE_WR_BYPASS_EN
        exp_hazard = 32'h2222_2222;
`else
        exp_hazard = 32'h1111_1111;
`endif
        checkOne("hazard", rd_data8, exp_hazard);
        readRegs(3'd5, 3'd0, 2'b11);
        checkOne("after_hazard", rd_data8[15:0], 32'h0000_2222);

        // Reset at sweep edge 4, with a write during the restarted sweep.
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 16'h0000, 2'b00);
        idle(3);
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 16'h0000, 2'b00);
        idle(1);
        writeReg(3'd2, 16'hBEEF, 2'b11);
        idle(5);
        checkOne("midsweep_busy7", {31'b0, busy8}, 32'd1);
        idle(1);
        checkOne("midsweep_busy8", {31'b0, busy8}, 32'd0);
        readRegs(3'd2, 3'd2, 2'b11);
        checkOne("r2_lost", rd_data8, 32'h0000_0000);

        // Out-of-range addresses on the DEPTH=6 instance.
        for (int i = 0; i < 6; i++) writeReg(3'(i), 16'h1000 + 16'(i * 16'h0101), 2'b11);
        writeReg(3'd7, 16'hFFFF, 2'b11);
        readRegs(3'd7, 3'd0, 2'b11);
        checkOne("oor_read6", rd_data6, 32'h1000_0000);
        for (int i = 0; i < 6; i += 2) readRegs(3'(i), 3'(i + 1), 2'b11);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 2'($urandom), 3'($urandom_range(0, 7)),
                          16'($urandom), 2'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
